// File: rtl/unpack_pkg.sv
// Shared helpers for the pack/unpack pair: lane-count width and count clamping.
package unpack_pkg;

  // Width of a lane-count field able to hold 0..d inclusive.
  function automatic int cnt_w(input int d);
    return $clog2(d) + 1;
  endfunction

  // Requested lane counts above d saturate to a full word.
  function automatic int clamp_cnt(input int cnt, input int d);
    return (cnt > d) ? d : cnt;
  endfunction

endpackage

// File: rtl/unpack.sv
// Wide-to-narrow serializer: one W*D word in, up to D W-bit beats out on a stb/rdy stream.
module unpack
  import unpack_pkg::*;
#(
  parameter int W         = 8,
  parameter int D         = 2,
  parameter int MSB_FIRST = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_stb,
  input  logic [W*D-1:0]        s_dat,
  input  logic [cnt_w(D)-1:0]   s_cnt,
  output logic                  s_rdy,
  output logic                  m_stb,
  output logic [W-1:0]          m_dat,
  output logic                  m_lst,
  input  logic                  m_rdy
);

  localparam int CW = cnt_w(D);
  localparam int IW = CW - 1;

  logic [W*D-1:0] hold;
  logic [IW-1:0]  idx;
  logic [CW-1:0]  n;
  logic [CW-1:0]  n_in;
  logic           acc;

  function automatic logic [W-1:0] lane_of(input logic [W*D-1:0] word, input logic [IW-1:0] i);
    logic [W-1:0] r;
    int           lane;
    r    = '0;
    lane = (MSB_FIRST != 0) ? (D - 1 - int'(i)) : int'(i);
    for (int k = 0; k < D; k++)
      if (k == lane) r = word[k*W +: W];
    return r;
  endfunction

  assign n_in  = CW'(clamp_cnt(int'(s_cnt), D));
  assign m_dat = lane_of(hold, idx);
  assign m_lst = ({1'b0, idx} + CW'(1)) == n;
  // The final beat handing off frees the slot in the same cycle, so words stream with no bubble.
  assign s_rdy = ~m_stb | (m_rdy & m_lst);
  assign acc   = s_stb & s_rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_stb <= 1'b0;
      idx   <= '0;
      n     <= '0;
    end else if (acc) begin
      n     <= n_in;
      idx   <= '0;
      m_stb <= (n_in != '0);
    end else if (m_stb & m_rdy) begin
      if (m_lst) begin
        m_stb <= 1'b0;
        idx   <= '0;
      end else begin
        idx   <= idx + IW'(1);
      end
    end
  end

  // Data register carries no reset; it is only observed while m_stb is set.
  always_ff @(posedge clk)
    if (acc) hold <= s_dat;

endmodule

// File: tb/tb_unpack.sv
// Drives LSB-first and MSB-first instances in lockstep against a beat-queue reference model.
module tb_unpack;

  localparam int W = 8;
  localparam int D = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_stb;
  logic [W*D-1:0] s_dat;
  logic [2:0]    s_cnt;
  logic          m_rdy;
  logic          s_rdy0, m_stb0, m_lst0;
  logic          s_rdy1, m_stb1, m_lst1;
  logic [W-1:0]  m_dat0, m_dat1;

  int total = 0;
  int bad   = 0;

  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [7:0] obs0[$];
  logic [7:0] obs1[$];
  logic       last_acc;

  always #5 clk = ~clk;

  unpack #(.W(W), .D(D), .MSB_FIRST(0)) u0 (
    .clk(clk), .rst(rst), .s_stb(s_stb), .s_dat(s_dat), .s_cnt(s_cnt), .s_rdy(s_rdy0),
    .m_stb(m_stb0), .m_dat(m_dat0), .m_lst(m_lst0), .m_rdy(m_rdy));

  unpack #(.W(W), .D(D), .MSB_FIRST(1)) u1 (
    .clk(clk), .rst(rst), .s_stb(s_stb), .s_dat(s_dat), .s_cnt(s_cnt), .s_rdy(s_rdy1),
    .m_stb(m_stb1), .m_dat(m_dat1), .m_lst(m_lst1), .m_rdy(m_rdy));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expand a word into its expected beat list for both lane orders.
  task automatic fill(input logic [31:0] word, input int cnt);
    int n;
    n = (cnt > D) ? D : cnt;
    for (int i = 0; i < n; i++) begin
      q0.push_back({i == n - 1, 8'((word >> (8 * i)) & 32'hFF)});
      q1.push_back({i == n - 1, 8'((word >> (8 * (D - 1 - i))) & 32'hFF)});
    end
  endtask

  // One clock: check outputs mid-cycle, advance the model, then step past the edge.
  task automatic step();
    logic er;
    @(negedge clk);
    er = (q0.size() == 0) || (q0.size() == 1 && m_rdy);
    chk("s_rdy0", s_rdy0, er);
    chk("s_rdy1", s_rdy1, er);
    chk("m_stb0", m_stb0, q0.size() != 0);
    chk("m_stb1", m_stb1, q1.size() != 0);
    if (q0.size() != 0) begin
      chk("m_dat0", m_dat0, q0[0][7:0]);
      chk("m_lst0", m_lst0, q0[0][8]);
      chk("m_dat1", m_dat1, q1[0][7:0]);
      chk("m_lst1", m_lst1, q1[0][8]);
      if (m_rdy) begin
        obs0.push_back(m_dat0);
        obs1.push_back(m_dat1);
        void'(q0.pop_front());
        void'(q1.pop_front());
      end
    end
    last_acc = s_stb && er;
    if (last_acc) fill(s_dat, int'(s_cnt));
    @(posedge clk);
    #1;
  endtask

  // Present a word and hold it until the model says it was taken.
  task automatic send(input logic [31:0] word, input int cnt);
    int guard;
    s_stb = 1'b1;
    s_dat = word;
    s_cnt = 3'(cnt);
    guard = 0;
    last_acc = 1'b0;
    while (!last_acc && guard < 20) begin
      step();
      guard++;
    end
    if (!last_acc) chk("accept_timeout", 0, 1);
  endtask

  task automatic drain(input int cycles);
    s_stb = 1'b0;
    for (int i = 0; i < cycles; i++) step();
  endtask

  initial begin
    rst = 1'b1; s_stb = 1'b0; s_dat = '0; s_cnt = '0; m_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_stb", m_stb0, 0);
    chk("rst_s_rdy", s_rdy0, 1);
    rst = 1'b0;
    m_rdy = 1'b1;

    // Single full word, then the MSB-first view of the same beats.
    obs0.delete(); obs1.delete();
    send(32'h44332211, 4);
    drain(5);
    chk("t1_n", obs0.size(), 4);
    if (obs0.size() == 4) begin
      chk("t1_b0", obs0[0], 8'h11); chk("t1_b3", obs0[3], 8'h44);
      chk("t1_msb_b0", obs1[0], 8'h44); chk("t1_msb_b3", obs1[3], 8'h11);
    end

    // Back-to-back words with no idle beat between them.
    obs0.delete();
    send(32'h44332211, 4);
    send(32'h88776655, 4);
    drain(5);
    chk("t2_n", obs0.size(), 8);
    if (obs0.size() == 8) chk("t2_b4", obs0[4], 8'h55);

    // Backpressure stalls.
    obs0.delete();
    send(32'h44332211, 4);
    s_stb = 1'b0;
    foreach (obs1[i]) obs1[i] = obs1[i];
    m_rdy = 1'b1; step();
    m_rdy = 1'b0; step(); step();
    m_rdy = 1'b1; step(); step(); step();
    drain(2);
    chk("t3_n", obs0.size(), 4);
    if (obs0.size() == 4) chk("t3_b1", obs0[1], 8'h22);

    // Partial, oversized and empty counts.
    obs0.delete();
    send(32'hDDCCBBAA, 2); drain(3);
    send(32'h44332211, 7); drain(5);
    send(32'h12345678, 0); drain(2);
    chk("t4_n", obs0.size(), 6);
    if (obs0.size() == 6) chk("t4_b1", obs0[1], 8'hBB);

    // Three-lane MSB-first.
    obs1.delete();
    send(32'h44332211, 3); drain(4);
    chk("t5_n", obs1.size(), 3);
    if (obs1.size() == 3) chk("t5_b2", obs1[2], 8'h22);

    // Asynchronous reset mid-word after two beats.
    send(32'h44332211, 4);
    s_stb = 1'b0;
    step(); step();
    #2;
    rst = 1'b1;
    #1;
    chk("t6_m_stb0", m_stb0, 0);
    chk("t6_m_stb1", m_stb1, 0);
    q0.delete(); q1.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    obs0.delete();
    send(32'h0000BEEF, 2); drain(3);
    chk("t6_n", obs0.size(), 2);
    if (obs0.size() == 2) chk("t6_b1", obs0[1], 8'hBE);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      s_stb = ($urandom_range(0, 3) != 0);
      s_dat = $urandom;
      s_cnt = 3'($urandom_range(0, 7));
      m_rdy = ($urandom_range(0, 3) != 0);
      step();
    end
    m_rdy = 1'b1;
    drain(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
